// File: rtl/aes_pkg.sv
// Shared AES types plus key-schedule sequencing constants, state encoding
// and the GF(2^8) doubling used to step the round constant.
package aes_pkg;
  typedef logic [127:0] aes_128;
  typedef logic [7:0]   ByteType;
  typedef logic [3:0]   rk_idx_t;

  localparam int      NUM_ROUNDS = 10;
  localparam ByteType RCON_INIT  = 8'h01;

  typedef enum logic [2:0] {
    KS_IDLE,
    KS_LOAD,
    KS_ISSUE,
    KS_WAIT,
    KS_STORE,
    KS_DONE
  } ks_state_t;

  function automatic ByteType xtime(input ByteType b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_rk_buffer.sv
// Round-key storage: one write port, one registered range-checked read port.
// Contents are not reset; the read qualifier alone gates visibility.
module aes_rk_buffer
  import aes_pkg::*;
#(
  parameter int NUM_RK = 11
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_we,
  input  rk_idx_t i_waddr,
  input  aes_128  i_wdata,
  input  logic    i_rd_en,
  input  logic    i_rd_ok,
  input  rk_idx_t i_rd_addr,
  output aes_128  o_rd_data,
  output logic    o_rd_valid
);
  localparam rk_idx_t LAST = rk_idx_t'(NUM_RK - 1);

  aes_128 r_mem [NUM_RK];
  aes_128 r_rd_data;
  logic   r_rd_valid;
  logic   w_rd_hit;

  assign w_rd_hit = i_rd_en && i_rd_ok && (i_rd_addr <= LAST);

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr <= LAST)) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_hit;
      r_rd_data  <= w_rd_hit ? r_mem[i_rd_addr] : '0;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequences aes_key_gen through the ten AES-128 expansion rounds, captures
// every round key and serves them through a registered read port.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KG_LAT = 2,
  parameter int NUM_RK = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  aes_128       key_i,
  input  aes_128       kg_key_i,
  output logic         kg_en,
  output logic         kg_gen_key,
  output logic         kg_next_rnd,
  output logic [3:0]   kg_rnd_number,
  output ByteType      kg_r_con,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data,
  output logic         rk_rd_valid
);
  localparam rk_idx_t    LAST_RND  = rk_idx_t'(NUM_ROUNDS);
  localparam logic [2:0] WCNT_INIT = 3'(KG_LAT - 1);

  ks_state_t  r_state, w_next;
  rk_idx_t    r_round;
  ByteType    r_rcon;
  logic [2:0] r_wcnt;
  logic       r_keys_valid;
  logic       w_busy, w_gen_key, w_next_rnd, w_done, w_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= KS_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_busy     = 1'b0;
    w_gen_key  = 1'b0;
    w_next_rnd = 1'b0;
    w_done     = 1'b0;
    w_we       = 1'b0;
    case (r_state)
      KS_IDLE:  if (start) w_next = KS_LOAD;
      KS_LOAD: begin
        w_busy    = 1'b1;
        w_gen_key = 1'b1;
        w_we      = 1'b1;
        w_next    = KS_ISSUE;
      end
      KS_ISSUE: begin
        w_busy     = 1'b1;
        w_next_rnd = 1'b1;
        w_next     = KS_WAIT;
      end
      KS_WAIT: begin
        w_busy = 1'b1;
        if (r_wcnt == 3'd0) w_next = KS_STORE;
      end
      KS_STORE: begin
        w_busy = 1'b1;
        w_we   = 1'b1;
        w_next = (r_round == LAST_RND) ? KS_DONE : KS_ISSUE;
      end
      KS_DONE: begin
        w_done = 1'b1;
        w_next = KS_IDLE;
      end
      default: w_next = KS_IDLE;
    endcase
  end

  // Round and rcon are held from ISSUE through STORE so the generator sees
  // stable control for the whole round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round      <= '0;
      r_rcon       <= 8'h00;
      r_wcnt       <= '0;
      r_keys_valid <= 1'b0;
    end else begin
      case (r_state)
        KS_IDLE: if (start) begin
          r_keys_valid <= 1'b0;
          r_round      <= '0;
          r_rcon       <= RCON_INIT;
        end
        KS_LOAD:  r_round <= 4'd1;
        KS_ISSUE: r_wcnt  <= WCNT_INIT;
        KS_WAIT:  if (r_wcnt != 3'd0) r_wcnt <= r_wcnt - 3'd1;
        KS_STORE: if (r_round != LAST_RND) begin
          r_rcon  <= xtime(r_rcon);
          r_round <= r_round + 4'd1;
        end
        KS_DONE:  r_keys_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  // r_round is 0 during LOAD, so one address mux covers both writers.
  aes_rk_buffer #(.NUM_RK(NUM_RK)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (r_round),
    .i_wdata    (w_gen_key ? key_i : kg_key_i),
    .i_rd_en    (rk_rd_en),
    .i_rd_ok    (r_keys_valid),
    .i_rd_addr  (rk_rd_addr),
    .o_rd_data  (rk_rd_data),
    .o_rd_valid (rk_rd_valid)
  );

  assign kg_en         = w_busy;
  assign busy          = w_busy;
  assign kg_gen_key    = w_gen_key;
  assign kg_next_rnd   = w_next_rnd;
  assign done          = w_done;
  assign keys_valid    = r_keys_valid;
  assign kg_rnd_number = r_round;
  assign kg_r_con      = r_rcon;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: three instances (KG_LAT 2, 1, 7) checked each
// cycle against a timeline model plus FIPS-197 literal round keys.
module tb_aes_key_sched_ctrl;
  localparam int NI = 3;
  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [7:0] RCT [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic int lat(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 7;
  endfunction

  logic clk, rst;
  logic [NI-1:0]        start, rd_en, kg_en, gen, nxt, busy, done, kv, rvld;
  logic [NI-1:0][127:0] key_i, kg_key, rdata;
  logic [NI-1:0][3:0]   rd_addr, rnd;
  logic [NI-1:0][7:0]   rcon;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_key_sched_ctrl #(.KG_LAT(lat(g)), .NUM_RK(11)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .key_i(key_i[g]),
      .kg_key_i(kg_key[g]), .kg_en(kg_en[g]), .kg_gen_key(gen[g]),
      .kg_next_rnd(nxt[g]), .kg_rnd_number(rnd[g]), .kg_r_con(rcon[g]),
      .busy(busy[g]), .done(done[g]), .keys_valid(kv[g]),
      .rk_rd_en(rd_en[g]), .rk_rd_addr(rd_addr[g]),
      .rk_rd_data(rdata[g]), .rk_rd_valid(rvld[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference key expansion ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y; logic [15:0] d;
    y = 8'h00;
    if (x != 8'h00) begin
      y = 8'h01;
      for (int k = 0; k < 254; k++) y = gmul(y, x);
    end
    d = {y, y};
    return y ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [127:0] sched [NI][11];
  task automatic expand(input logic [127:0] k, input int i);
    logic [31:0] w [44]; logic [31:0] tmp;
    for (int j = 0; j < 4; j++) w[j] = k[127-32*j -: 32];
    for (int j = 4; j < 44; j++) begin
      tmp = w[j-1];
      if (j % 4 == 0) tmp = subw({tmp[23:0], tmp[31:24]}) ^ {RCT[j/4-1], 24'h0};
      w[j] = w[j-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) sched[i][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- timeline model ----------------
  // t = edges since the edge that accepted start (-1 when idle).
  int t [NI];
  bit mkv [NI], fresh [NI], e_rv [NI];
  logic [127:0] e_rd [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      t[i] = -1; mkv[i] = 0; fresh[i] = 1; e_rv[i] = 0; e_rd[i] = '0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          t[i] = -1; mkv[i] = 0; fresh[i] = 1; e_rv[i] = 0; e_rd[i] = '0;
        end else begin
          e_rv[i] = rd_en[i] && mkv[i] && (rd_addr[i] <= 4'd10);
          e_rd[i] = e_rv[i] ? sched[i][rd_addr[i]] : '0;
          if (t[i] == -1) begin
            if (start[i]) begin t[i] = 0; mkv[i] = 0; fresh[i] = 0; end
          end else if (t[i] < 1 + 10*(lat(i)+2)) t[i]++;
          else begin t[i] = -1; mkv[i] = 1; end
        end
      end
    end
  end

  // aes_key_gen stand-in: garbage until KG_LAT cycles after next_rnd.
  initial begin
    int cnt [NI]; int kr [NI];
    for (int i = 0; i < NI; i++) begin cnt[i] = 0; kr[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin cnt[i] = 0; kr[i] = 0; end
        else begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0 && kr[i] <= 10) kg_key[i] = sched[i][kr[i]];
          end
          if (gen[i]) kr[i] = 0;
          if (nxt[i]) begin
            kr[i]++; cnt[i] = lat(i);
            kg_key[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
          end
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) for (int i = 0; i < NI; i++) begin
      int L, tot, r; bit act;
      L = lat(i); tot = 1 + 10*(L+2);
      act = (t[i] >= 0) && (t[i] < tot);
      chk($sformatf("u%0d busy t=%0d", i, t[i]), 128'(busy[i]), 128'(act));
      chk($sformatf("u%0d kg_en t=%0d", i, t[i]), 128'(kg_en[i]), 128'(act));
      chk($sformatf("u%0d gen_key t=%0d", i, t[i]), 128'(gen[i]), 128'(t[i] == 0));
      chk($sformatf("u%0d next_rnd t=%0d", i, t[i]), 128'(nxt[i]),
          128'(act && t[i] >= 1 && (t[i]-1) % (L+2) == 0));
      chk($sformatf("u%0d done t=%0d", i, t[i]), 128'(done[i]), 128'(t[i] == tot));
      chk($sformatf("u%0d keys_valid", i), 128'(kv[i]), 128'(mkv[i]));
      chk($sformatf("u%0d rd_valid", i), 128'(rvld[i]), 128'(e_rv[i]));
      chk($sformatf("u%0d rd_data", i), rdata[i], e_rd[i]);
      if (act && t[i] >= 1) begin
        r = (t[i]-1) / (L+2) + 1;
        chk($sformatf("u%0d rnd t=%0d", i, t[i]), 128'(rnd[i]), 128'(r));
        chk($sformatf("u%0d rcon t=%0d", i, t[i]), 128'(rcon[i]), 128'(RCT[r-1]));
      end else if (t[i] == 0 || (t[i] == -1 && fresh[i])) begin
        chk($sformatf("u%0d rnd idle/load", i), 128'(rnd[i]), 128'(0));
        if (t[i] == -1) chk($sformatf("u%0d rcon reset", i), 128'(rcon[i]), 128'(0));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int gcnt, ncnt, latv;
  logic [7:0] seen_rc [10];
  logic [3:0] seen_rn [10];

  task automatic kick(input int i, input logic [127:0] k);
    @(negedge clk); key_i[i] = k; start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
  endtask

  // Entered at the LOAD-cycle negedge; returns edges until done seen.
  task automatic run(input int i, input bit inj, input int abort_at, output int lv);
    int m; m = 0; gcnt = 0; ncnt = 0; lv = -1;
    while (m < 200 && !done[i]) begin
      if (gen[i]) gcnt++;
      if (nxt[i]) begin
        if (ncnt < 10) begin seen_rc[ncnt] = rcon[i]; seen_rn[ncnt] = rnd[i]; end
        ncnt++;
      end
      if (inj && m == 10) begin start[i] = 1'b1; rd_en[i] = 1'b1; rd_addr[i] = 4'd0; end
      if (inj && m == 11) begin start[i] = 1'b0; rd_en[i] = 1'b0; end
      if (m == abort_at) begin
        #1 rst = 1'b1;
        #1;
        chk("async rst outs", {busy[i], kg_en[i], gen[i], nxt[i], done[i], kv[i],
                                rvld[i], rnd[i], rcon[i]}, '0);
        chk("async rst rdata", rdata[i], '0);
        return;
      end
      @(negedge clk); m++;
    end
    lv = m;
  endtask

  initial begin
    rst = 1'b1; start = '0; rd_en = '0; rd_addr = '0; key_i = '0; kg_key = '0;
    for (int i = 0; i < NI; i++) for (int r = 0; r < 11; r++) sched[i][r] = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset busy/kv/done", {busy[0], kv[0], done[0], rvld[0]}, '0);
    chk("reset rcon", 128'(rcon[0]), 128'(0));

    expand(K1, 0);
    chk("model rk1", sched[0][1], RK1);
    chk("model rk10", sched[0][10], RK10);

    // nominal run with a stray start and a busy read during round 3
    kick(0, K1);
    run(0, 1'b1, -1, latv);
    chk("latency L2", 128'(latv), 128'(41));
    chk("gen_key cycles", 128'(gcnt), 128'(1));
    chk("next_rnd cycles", 128'(ncnt), 128'(10));
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("rcon seq %0d", k), 128'(seen_rc[k]), 128'(RCT[k]));
      chk($sformatf("rnd seq %0d", k), 128'(seen_rn[k]), 128'(k + 1));
    end

    // back-to-back reads 0, 10, 11
    @(negedge clk); rd_en[0] = 1'b1; rd_addr[0] = 4'd0;
    @(negedge clk);
    chk("rd0", {127'(rvld[0]), 1'b0} ^ 128'(0), {127'(1), 1'b0});
    chk("rd0 data", rdata[0], K1);
    rd_addr[0] = 4'd10;
    @(negedge clk);
    chk("rd10 valid", 128'(rvld[0]), 128'(1));
    chk("rd10 data", rdata[0], RK10);
    rd_addr[0] = 4'd11;
    @(negedge clk);
    chk("rd11 valid", 128'(rvld[0]), 128'(0));
    chk("rd11 data", rdata[0], '0);
    rd_en[0] = 1'b0;

    // restart with a same-edge read, then abort in round 5 WAIT
    @(negedge clk); start[0] = 1'b1; rd_en[0] = 1'b1; rd_addr[0] = 4'd1;
    @(negedge clk); start[0] = 1'b0; rd_en[0] = 1'b0;
    chk("same-edge rd valid", 128'(rvld[0]), 128'(1));
    chk("same-edge rd data", rdata[0], RK1);
    chk("kv cleared at load", 128'(kv[0]), 128'(0));
    run(0, 1'b0, 18, latv);
    @(posedge clk); #2 rst = 1'b0;

    // second run with a new key, read everything back
    expand(K2, 0);
    kick(0, K2);
    run(0, 1'b0, -1, latv);
    chk("latency rerun", 128'(latv), 128'(41));
    for (int a = 0; a < 11; a++) begin
      @(negedge clk); rd_en[0] = 1'b1; rd_addr[0] = 4'(a);
    end
    @(negedge clk); rd_en[0] = 1'b0;
    chk("rerun key0 literal", sched[0][0], K2);

    // other latencies
    for (int i = 1; i < NI; i++) begin
      expand(K1, i);
      kick(i, K1);
      run(i, 1'b0, -1, latv);
      chk($sformatf("latency L%0d", lat(i)), 128'(latv), 128'(i == 1 ? 31 : 91));
      @(negedge clk); rd_en[i] = 1'b1; rd_addr[i] = 4'd10;
      @(negedge clk); rd_en[i] = 1'b0;
      chk($sformatf("u%0d rd10", i), rdata[i], RK10);
      chk($sformatf("u%0d rd10 valid", i), 128'(rvld[i]), 128'(1));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end
endmodule
